bp_be_fe_replay_queue: RTL and testbench
========================================

Name: bp_be_fe_replay_queue

Overview:
- Parametrised successor to the single-entry FE-queue handshake (yumi/deq/roll/clr) used at the backend boundary.
- Buffers fetched-instruction packets between FE and the BE scheduler in a circular buffer with three pointers: write, speculative issue, commit.
- Adds multi-entry commit per cycle, replay of issued-but-uncommitted packets (roll), flush of all uncommitted packets (clr), and occupancy reporting.

Parameters:
- els_p, 8: entries; power of two, >= 2.
- data_width_p, 128: packet width (fe_queue_width_lp at integration).
- cmt_width_p, 2: maximum entries committed in one cycle; 1 <= cmt_width_p <= els_p.
- ptr_width_lp (local), $clog2(els_p)+1: pointer width, including the wrap bit.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- reset_n_i  in  1  asynchronous active-low reset.
- enq_data_i  in  data_width_p  packet from FE.
- enq_v_i  in  1  packet valid.
- enq_ready_o  out  1  high when the queue is not full.
- issue_data_o  out  data_width_p  packet at the issue pointer.
- issue_v_o  out  1  an unissued packet is present.
- issue_yumi_i  in  1  scheduler consumes issue_data_o; legal only when issue_v_o is high.
- deq_cnt_i  in  $clog2(cmt_width_p+1)  number of issued entries retired this cycle.
- roll_i  in  1  replay: issue pointer returns to the commit pointer.
- clr_i  in  1  flush: discard all uncommitted entries.
- occupancy_o  out  $clog2(els_p+1)  entries held (write pointer minus commit pointer).
- inflight_o  out  $clog2(els_p+1)  issued-uncommitted entries (issue pointer minus commit pointer).

Behaviour:
- Pointers wptr, rptr, cptr are ptr_width_lp wide. The wrap bit distinguishes full from empty. Pointer sums wrap modulo 2*els_p.
- Invariant: cptr <= rptr <= wptr in modular order.
- While reset_n_i is low: all pointers 0, issue_v_o=0, enq_ready_o=1, occupancy_o=0, inflight_o=0. Storage contents are not reset.
- Full: wptr and cptr have equal index and differing wrap bit. enq_ready_o = !full.
- enq_ready_o is independent of clr_i, roll_i and deq_cnt_i in the same cycle, so there are no combinational paths from them.
- Enqueue: when enq_v_i & enq_ready_o, write the entry at wptr and increment wptr. Without the optional bypass, the packet is visible on issue_v_o the following cycle.
- Issue: issue_v_o = (rptr != wptr). issue_data_o is a combinational read of the storage at rptr. issue_yumi_i increments rptr.
- Commit: cptr_next = cptr + deq_cnt_i.
  - deq_cnt_i > inflight_o is illegal; the simulation assertion fires.
  - deq_cnt_i > cmt_width_p is illegal.
- Roll: rptr_next = cptr_next. Roll takes priority over issue_yumi_i in the same cycle. Same-cycle commits are honoured first.
- Clr: rptr_next = wptr_next = cptr_next.
  - Takes priority over roll, yumi and a same-cycle enqueue; the enqueued packet is accepted by the handshake and then discarded.
- Priority order: reset > clr > roll > yumi; enqueue and commit are always applied.
- Full and a same-cycle commit: enq_ready_o stays low this cycle. The freed space is visible next cycle.
- Outputs occupancy_o and inflight_o are combinational from the registered pointers.

Optional Feature:
- Macro: BP_BE_FE_REPLAY_QUEUE_BYPASS_EN.
- Defined: when the queue holds no unissued entry (rptr == wptr) and enq_v_i is high:
  - issue_v_o=1 and issue_data_o=enq_data_i in the same cycle.
  - If issue_yumi_i is also high, the entry is still written and both wptr and rptr advance.
  - A bypassed entry remains replayable by roll.
  - A same-cycle clr_i suppresses the bypass (issue_v_o=0).
- Undefined: one-cycle minimum latency, no enq-to-issue combinational path.

Decomposition:
- bp_be_pkg gains:
  - the pointer-increment helper function (modular add of a count to a ptr_width_lp value);
  - the occupancy-difference function.
- No new typedefs; packet contents are opaque.
- One natural sub-module: bp_be_fe_replay_queue_ptr, a wrap-bit circular pointer register.
  - Inputs: add count, load enable, load value.
  - Instantiated three times, with reset_n_i wired to each.
- The storage array stays inline as flops (els_p x data_width_p). It is written on enqueue and read at rptr.

Test Plan:
- Reset then fill: 8 enqueues of 0x1..0x8 with no yumi. enq_ready_o drops after the 8th; occupancy_o=8; issue_data_o=0x1; a 9th enq_v_i is not accepted.
- Issue 3 with yumi (0x1,0x2,0x3), deq_cnt_i=2, then roll_i. Next cycle: issue_data_o=0x3, inflight_o=0, occupancy_o=6.
- Same cycle: roll_i, issue_yumi_i and deq_cnt_i=1 with inflight 2 -> cptr+1, rptr=cptr, issue_data_o is the second issued packet.
- clr_i together with enq_v_i (0xAA) with occupancy 5 and inflight 2. Next cycle: occupancy_o=0, issue_v_o=0, 0xAA discarded; a later enqueue of 0xBB issues 0xBB.
- Wrap-around: 20 enq/yumi/deq cycles at steady state. Pointer wrap bit toggles, full is never falsely asserted, data order is preserved.
- With BP_BE_FE_REPLAY_QUEUE_BYPASS_EN, empty queue, enq 0x55 with yumi same cycle -> issue_data_o=0x55 that cycle; then roll_i re-presents 0x55.

Source files
------------

// File: rtl/bp_be_pkg.sv
// bp_be_pkg: shared helpers for the backend FE replay queue.
// Pointer math lives here so every pointer instance wraps identically.
package bp_be_pkg;

    // Modular add of a count to a wrap-bit pointer (range 2*els).
    function automatic logic [31:0] ptr_add(input logic [31:0] ptr, input logic [31:0] cnt, input int els);
        return (ptr + cnt) & 32'(2 * els - 1);
    endfunction

    // Entries between two wrap-bit pointers (a ahead of b).
    function automatic logic [31:0] ptr_diff(input logic [31:0] a, input logic [31:0] b, input int els);
        return (a - b) & 32'(2 * els - 1);
    endfunction

endpackage

// File: rtl/bp_be_fe_replay_queue_ptr.sv
// bp_be_fe_replay_queue_ptr: wrap-bit circular pointer register with add and load.
// next_o exposes the pre-register value so siblings can follow same-cycle updates.
module bp_be_fe_replay_queue_ptr
    import bp_be_pkg::*;
#(
    parameter int els_p       = 8,
    parameter int cnt_width_p = 1,
    localparam int ptr_width_lp = $clog2(els_p) + 1
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic [cnt_width_p-1:0]  add_i,
    input  logic                    load_v_i,
    input  logic [ptr_width_lp-1:0] load_i,
    output logic [ptr_width_lp-1:0] ptr_o,
    output logic [ptr_width_lp-1:0] next_o
);

    logic [ptr_width_lp-1:0] ptr_q, ptr_d;

    assign ptr_d  = load_v_i ? load_i : ptr_width_lp'(ptr_add(32'(ptr_q), 32'(add_i), els_p));
    assign ptr_o  = ptr_q;
    assign next_o = ptr_d;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) ptr_q <= '0;
        else            ptr_q <= ptr_d;
    end

endmodule

// File: rtl/bp_be_fe_replay_queue.sv
// bp_be_fe_replay_queue: FE->BE packet queue with write/issue/commit pointers, roll and clr.
// Define BP_BE_FE_REPLAY_QUEUE_BYPASS_EN for a same-cycle enq-to-issue bypass when no entry is unissued.
module bp_be_fe_replay_queue
    import bp_be_pkg::*;
#(
    parameter int els_p        = 8,
    parameter int data_width_p = 128,
    parameter int cmt_width_p  = 2,
    localparam int ptr_width_lp = $clog2(els_p) + 1,
    localparam int cnt_width_lp = $clog2(cmt_width_p + 1),
    localparam int occ_width_lp = $clog2(els_p + 1),
    localparam int idx_width_lp = $clog2(els_p)
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic [data_width_p-1:0] enq_data_i,
    input  logic                    enq_v_i,
    output logic                    enq_ready_o,
    output logic [data_width_p-1:0] issue_data_o,
    output logic                    issue_v_o,
    input  logic                    issue_yumi_i,
    input  logic [cnt_width_lp-1:0] deq_cnt_i,
    input  logic                    roll_i,
    input  logic                    clr_i,
    output logic [occ_width_lp-1:0] occupancy_o,
    output logic [occ_width_lp-1:0] inflight_o
);

    logic [ptr_width_lp-1:0] wptr, rptr, cptr, cptr_next, wptr_next_unused, rptr_next_unused;
    logic [data_width_p-1:0] mem_q [els_p];
    logic                    full, enq_fire, no_unissued;

    assign full        = (wptr[idx_width_lp-1:0] == cptr[idx_width_lp-1:0])
                       & (wptr[ptr_width_lp-1] != cptr[ptr_width_lp-1]);
    assign enq_ready_o = !full;
    assign enq_fire    = enq_v_i & enq_ready_o;
    assign no_unissued = (rptr == wptr);

    bp_be_fe_replay_queue_ptr #(.els_p(els_p), .cnt_width_p(cnt_width_lp)) cptr_reg (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .add_i(deq_cnt_i),
        .load_v_i(1'b0), .load_i('0), .ptr_o(cptr), .next_o(cptr_next)
    );

    // Roll and clr both rewind to the post-commit pointer, so same-cycle commits are kept.
    bp_be_fe_replay_queue_ptr #(.els_p(els_p), .cnt_width_p(1)) rptr_reg (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .add_i(issue_yumi_i),
        .load_v_i(clr_i | roll_i), .load_i(cptr_next), .ptr_o(rptr), .next_o(rptr_next_unused)
    );

    bp_be_fe_replay_queue_ptr #(.els_p(els_p), .cnt_width_p(1)) wptr_reg (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .add_i(enq_fire),
        .load_v_i(clr_i), .load_i(cptr_next), .ptr_o(wptr), .next_o(wptr_next_unused)
    );

    always_ff @(posedge clk_i) begin
        if (enq_fire) mem_q[wptr[idx_width_lp-1:0]] <= enq_data_i;
    end

`ifdef BP_BE_FE_REPLAY_QUEUE_BYPASS_EN
    logic bypass;
    assign bypass       = no_unissued & enq_fire & !clr_i;
    assign issue_v_o    = !no_unissued | bypass;
    assign issue_data_o = no_unissued ? enq_data_i : mem_q[rptr[idx_width_lp-1:0]];
`else
    assign issue_v_o    = !no_unissued;
    assign issue_data_o = mem_q[rptr[idx_width_lp-1:0]];
`endif

    assign occupancy_o = occ_width_lp'(ptr_diff(32'(wptr), 32'(cptr), els_p));
    assign inflight_o  = occ_width_lp'(ptr_diff(32'(rptr), 32'(cptr), els_p));

    always @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (occ_width_lp'(deq_cnt_i) <= inflight_o)
                else $error("deq_cnt_i %0d exceeds inflight %0d", deq_cnt_i, inflight_o);
            assert (32'(deq_cnt_i) <= cmt_width_p)
                else $error("deq_cnt_i %0d exceeds cmt_width_p", deq_cnt_i);
            assert (!issue_yumi_i || issue_v_o)
                else $error("issue_yumi_i without issue_v_o");
        end
    end

endmodule

// File: tb/tb_bp_be_fe_replay_queue.sv
// tb_bp_be_fe_replay_queue: directed self-checking bench for bp_be_fe_replay_queue.
module tb_bp_be_fe_replay_queue;

    logic         clk_i = 1'b0;
    logic         reset_n_i = 1'b0;
    logic [127:0] enq_data_i = '0;
    logic         enq_v_i = 1'b0;
    logic         enq_ready_o;
    logic [127:0] issue_data_o;
    logic         issue_v_o;
    logic         issue_yumi_i = 1'b0;
    logic [1:0]   deq_cnt_i = '0;
    logic         roll_i = 1'b0;
    logic         clr_i = 1'b0;
    logic [3:0]   occupancy_o;
    logic [3:0]   inflight_o;

    int checks = 0;
    int errors = 0;

    bp_be_fe_replay_queue #(.els_p(8), .data_width_p(128), .cmt_width_p(2)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .enq_data_i(enq_data_i), .enq_v_i(enq_v_i),
        .enq_ready_o(enq_ready_o), .issue_data_o(issue_data_o), .issue_v_o(issue_v_o),
        .issue_yumi_i(issue_yumi_i), .deq_cnt_i(deq_cnt_i), .roll_i(roll_i), .clr_i(clr_i),
        .occupancy_o(occupancy_o), .inflight_o(inflight_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_occ", 128'(occupancy_o), 128'd0);
        chk("rst_infl", 128'(inflight_o), 128'd0);
        chk("rst_issue_v", 128'(issue_v_o), 128'd0);
        chk("rst_ready", 128'(enq_ready_o), 128'd1);
        reset_n_i = 1'b1;
        tick();

        // fill 0x1..0x8
        for (int i = 1; i <= 8; i++) begin
            chk("fill_ready", 128'(enq_ready_o), 128'd1);
            enq_v_i = 1'b1;
            enq_data_i = 128'(i);
            tick();
        end
        chk("full_ready", 128'(enq_ready_o), 128'd0);
        chk("full_occ", 128'(occupancy_o), 128'd8);
        chk("full_head", issue_data_o, 128'h1);
        chk("full_issue_v", 128'(issue_v_o), 128'd1);
        enq_data_i = 128'h9;
        tick();
        enq_v_i = 1'b0;
        chk("ninth_rejected", 128'(occupancy_o), 128'd8);

        // issue 3, commit 2, roll
        for (int i = 1; i <= 3; i++) begin
            chk("issue_order", issue_data_o, 128'(i));
            issue_yumi_i = 1'b1;
            tick();
        end
        issue_yumi_i = 1'b0;
        chk("infl3", 128'(inflight_o), 128'd3);
        deq_cnt_i = 2'd2;
        tick();
        deq_cnt_i = 2'd0;
        chk("after_deq_occ", 128'(occupancy_o), 128'd6);
        chk("after_deq_ready", 128'(enq_ready_o), 128'd1);
        roll_i = 1'b1;
        tick();
        roll_i = 1'b0;
        chk("roll_data", issue_data_o, 128'h3);
        chk("roll_infl", 128'(inflight_o), 128'd0);
        chk("roll_occ", 128'(occupancy_o), 128'd6);

        // issue 0x3,0x4 then roll+yumi+deq1 together
        issue_yumi_i = 1'b1;
        tick();
        tick();
        chk("infl2", 128'(inflight_o), 128'd2);
        roll_i = 1'b1;
        deq_cnt_i = 2'd1;
        tick();
        roll_i = 1'b0;
        deq_cnt_i = 2'd0;
        issue_yumi_i = 1'b0;
        chk("roll_yumi_data", issue_data_o, 128'h4);
        chk("roll_yumi_infl", 128'(inflight_o), 128'd0);
        chk("roll_yumi_occ", 128'(occupancy_o), 128'd5);

        // inflight 2 (0x4,0x5), then clr with enq 0xAA
        issue_yumi_i = 1'b1;
        tick();
        tick();
        issue_yumi_i = 1'b0;
        chk("pre_clr_occ", 128'(occupancy_o), 128'd5);
        chk("pre_clr_infl", 128'(inflight_o), 128'd2);
        clr_i = 1'b1;
        enq_v_i = 1'b1;
        enq_data_i = 128'hAA;
        tick();
        clr_i = 1'b0;
        enq_v_i = 1'b0;
        chk("clr_occ", 128'(occupancy_o), 128'd0);
        chk("clr_infl", 128'(inflight_o), 128'd0);
        chk("clr_issue_v", 128'(issue_v_o), 128'd0);
        chk("clr_ready", 128'(enq_ready_o), 128'd1);
        enq_v_i = 1'b1;
        enq_data_i = 128'hBB;
        tick();
        enq_v_i = 1'b0;
        chk("bb_v", 128'(issue_v_o), 128'd1);
        chk("bb_data", issue_data_o, 128'hBB);
        chk("bb_occ", 128'(occupancy_o), 128'd1);
        issue_yumi_i = 1'b1;
        tick();
        issue_yumi_i = 1'b0;
        deq_cnt_i = 2'd1;
        tick();
        deq_cnt_i = 2'd0;
        chk("drain_occ", 128'(occupancy_o), 128'd0);

        // steady-state wrap-around
        enq_v_i = 1'b1;
        enq_data_i = 128'h100;
        tick();
        for (int k = 0; k < 20; k++) begin
            chk("wrap_data", issue_data_o, 128'(32'h100 + k));
            chk("wrap_ready", 128'(enq_ready_o), 128'd1);
            enq_data_i = 128'(32'h101 + k);
            issue_yumi_i = 1'b1;
            deq_cnt_i = (k > 0) ? 2'd1 : 2'd0;
            tick();
        end
        enq_v_i = 1'b0;
        issue_yumi_i = 1'b0;
        deq_cnt_i = 2'd0;
        chk("wrap_occ", 128'(occupancy_o), 128'd2);
        chk("wrap_infl", 128'(inflight_o), 128'd1);
        chk("wrap_tail", issue_data_o, 128'h114);

        // empty then enqueue 0x55 with same-cycle yumi where legal
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        chk("empty_occ", 128'(occupancy_o), 128'd0);
        enq_v_i = 1'b1;
        enq_data_i = 128'h55;
        #1;
`ifdef BP_BE_FE_REPLAY_QUEUE_BYPASS_EN
        chk("bypass_v", 128'(issue_v_o), 128'd1);
        chk("bypass_data", issue_data_o, 128'h55);
        issue_yumi_i = 1'b1;
        tick();
        enq_v_i = 1'b0;
        issue_yumi_i = 1'b0;
        chk("bypass_infl", 128'(inflight_o), 128'd1);
        chk("bypass_drained", 128'(issue_v_o), 128'd0);
`else
        chk("nobypass_v", 128'(issue_v_o), 128'd0);
        tick();
        enq_v_i = 1'b0;
        chk("lat1_data", issue_data_o, 128'h55);
        issue_yumi_i = 1'b1;
        tick();
        issue_yumi_i = 1'b0;
        chk("lat1_infl", 128'(inflight_o), 128'd1);
`endif
        roll_i = 1'b1;
        tick();
        roll_i = 1'b0;
        chk("replay_v", 128'(issue_v_o), 128'd1);
        chk("replay_data", issue_data_o, 128'h55);
        chk("replay_infl", 128'(inflight_o), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
